// File: rtl/dram_lsu_pkg.sv
// Shared definitions for the DRAM load/store unit: access size encodings,
// FSM state encoding, data RAM address width and the alignment check.
package dram_lsu_pkg;

   localparam int RAM_AW = 16;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_RSVD = 2'b11
   } size_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ACCESS = 2'b01,
      ST_WRITE  = 2'b10,
      ST_RESP   = 2'b11
   } state_t;

   // True for a misaligned half/word or the reserved size.
   function automatic logic access_err(input size_t size, input logic [1:0] lo);
      logic err;
      case (size)
         SZ_BYTE: err = 1'b0;
         SZ_HALF: err = lo[0];
         SZ_WORD: err = (lo != 2'b00);
         default: err = 1'b1;
      endcase
      access_err = err;
   endfunction

endpackage

// File: rtl/dram_lsu_if.sv
// Pipeline-side request/response bundle of the load/store unit.
//   master : pipeline (drives request, accepts response)
//   slave  : dram_lsu (accepts request, drives response)
interface dram_lsu_if;

   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;

   modport master (
      output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );

endinterface

// File: rtl/dram_lsu_lane_align.sv
// Combinational lane logic for the load/store unit.
//   size/lane  : access size and byte offset within the word
//   sgn        : sign-extend loads when 1
//   rdata      : word read from the data RAM
//   wdata      : right-justified store data
//   load_data  : extracted and extended load value
//   merged     : rdata with the store lane replaced by wdata
module lsu_lane_align
   import dram_lsu_pkg::*;
(
   input  size_t       size,
   input  logic        sgn,
   input  logic [1:0]  lane,
   input  logic [31:0] rdata,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] merged
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel  = rdata[{lane, 3'b000} +: 8];
      half_sel  = rdata[{lane[1], 4'b0000} +: 16];
      load_data = rdata;
      merged    = rdata;
      case (size)
         SZ_BYTE: begin
            load_data = {{24{sgn & byte_sel[7]}}, byte_sel};
            merged[{lane, 3'b000} +: 8] = wdata[7:0];
         end
         SZ_HALF: begin
            load_data = {{16{sgn & half_sel[15]}}, half_sel};
            merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
         end
         default: begin
            load_data = rdata;
            merged    = wdata;
         end
      endcase
   end

endmodule

// File: rtl/dram_lsu.sv
// Load/store unit between the pipeline and a word-wide data RAM.
//   clk, rst_n : clock, asynchronous active-low reset
//   lsu        : request/response bundle (slave side)
//   ram_addr   : word index, captured addr[17:2]
//   ram_wdata  : word to write
//   ram_wen    : write enable (RAM writes on the falling edge)
//   ram_rdata  : combinational read data for ram_addr
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | ready for a request
// ST_ACCESS | RAM word read; load extracted, word store written,
//           | sub-word store merged
// ST_WRITE  | merged word written back (byte/half store)
// ST_RESP   | response held until resp_ready
module dram_lsu
   import dram_lsu_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   dram_lsu_if.slave         lsu,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   output logic              ram_wen,
   input  logic [31:0]       ram_rdata
);

   state_t      state_q, state_d;
   logic        cap_we;
   size_t       cap_size;
   logic        cap_sgn;
   logic [17:0] cap_addr;
   logic [31:0] cap_wdata;
   logic [31:0] merge_q;
   logic [31:0] rdata_q;
   logic        err_q;

   logic        accept;
   logic        req_err;
   logic        word_store;
   logic [31:0] load_data;
   logic [31:0] merged;

   assign accept     = (state_q == ST_IDLE) && lsu.req_valid;
   assign req_err    = access_err(size_t'(lsu.req_size), lsu.req_addr[1:0]);
   assign word_store = cap_we && (cap_size == SZ_WORD);

   lsu_lane_align u_align (
      .size      (cap_size),
      .sgn       (cap_sgn),
      .lane      (cap_addr[1:0]),
      .rdata     (ram_rdata),
      .wdata     (cap_wdata),
      .load_data (load_data),
      .merged    (merged)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (lsu.req_valid) state_d = req_err ? ST_RESP : ST_ACCESS;
         ST_ACCESS: state_d = (cap_we && !word_store) ? ST_WRITE : ST_RESP;
         ST_WRITE:  state_d = ST_RESP;
         ST_RESP:   if (lsu.resp_ready) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap_we    <= 1'b0;
         cap_size  <= SZ_BYTE;
         cap_sgn   <= 1'b0;
         cap_addr  <= '0;
         cap_wdata <= '0;
         merge_q   <= '0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         if (accept) begin
            cap_we    <= lsu.req_we;
            cap_size  <= size_t'(lsu.req_size);
            cap_sgn   <= lsu.req_signed;
            cap_addr  <= lsu.req_addr[17:0];
            cap_wdata <= lsu.req_wdata;
            rdata_q   <= '0;
            err_q     <= req_err;
         end
         if (state_q == ST_ACCESS) begin
            if (!cap_we) begin
               rdata_q <= load_data;
            end else if (word_store) begin
               // keep ram_wdata at the last written word once ACCESS ends
               merge_q <= cap_wdata;
            end else begin
               merge_q <= merged;
            end
         end
      end
   end

   assign ram_addr  = cap_addr[17:2];
   assign ram_wen   = ((state_q == ST_ACCESS) && word_store) || (state_q == ST_WRITE);
   assign ram_wdata = ((state_q == ST_ACCESS) && word_store) ? cap_wdata : merge_q;

   assign lsu.req_ready  = (state_q == ST_IDLE);
   assign lsu.resp_valid = (state_q == ST_RESP);
   assign lsu.resp_rdata = rdata_q;
   assign lsu.resp_err   = err_q;

endmodule

// File: tb/tb_dram_lsu.sv
// Self-checking bench for dram_lsu: directed scenarios followed by random
// traffic, checked against a word-array memory model with arithmetic lane
// extraction/merge.
module tb_dram_lsu;

   logic        clk;
   logic        rst_n;
   logic [15:0] ram_addr;
   logic [31:0] ram_wdata;
   logic        ram_wen;
   logic [31:0] ram_rdata;

   logic [31:0] ram   [0:65535];
   logic [31:0] model [0:65535];

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   int wen_count = 0;

   // expectations of the transaction in flight
   logic        exp_err;
   logic        exp_store;
   logic [31:0] exp_rdata;
   logic [31:0] exp_new;
   logic [15:0] exp_idx;
   int          exp_lat;
   int          exp_wen;
   int          wen_base;
   int          accept_cyc;
   int          idle_cyc;

   dram_lsu_if lsu_if ();

   dram_lsu dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .lsu       (lsu_if),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_wen   (ram_wen),
      .ram_rdata (ram_rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc++;

   assign ram_rdata = ram[ram_addr];

   always @(negedge clk) begin
      if (ram_wen === 1'b1) begin
         ram[ram_addr] = ram_wdata;
         wen_count++;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] sz,
                                              input logic sg, input logic [1:0] off);
      logic [31:0] v;
      case (sz)
         2'd0: begin
            v = (w >> (8 * off)) & 32'hFF;
            if (sg && v >= 32'd128) v = v | 32'hFFFF_FF00;
         end
         2'd1: begin
            v = (w >> (16 * (off / 2))) & 32'hFFFF;
            if (sg && v >= 32'd32768) v = v | 32'hFFFF_0000;
         end
         default: v = w;
      endcase
      return v;
   endfunction

   function automatic logic [31:0] model_store(input logic [31:0] w, input logic [1:0] sz,
                                               input logic [1:0] off, input logic [31:0] d);
      logic [31:0] mask;
      logic [31:0] shift;
      case (sz)
         2'd0: begin
            shift = 8 * off;
            mask  = 32'hFF << shift;
            return (w & ~mask) | ((d & 32'hFF) << shift);
         end
         2'd1: begin
            shift = 16 * (off / 2);
            mask  = 32'hFFFF << shift;
            return (w & ~mask) | ((d & 32'hFFFF) << shift);
         end
         default: return d;
      endcase
   endfunction

   // Present a request, wait for acceptance, then record expectations.
   // Returns #1 after the accepting edge.
   task automatic send(input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd);
      int w;
      lsu_if.req_we     = we;
      lsu_if.req_size   = sz;
      lsu_if.req_signed = sg;
      lsu_if.req_addr   = a;
      lsu_if.req_wdata  = wd;
      lsu_if.req_valid  = 1'b1;
      w = 0;
      while (lsu_if.req_ready !== 1'b1 && w < 20) begin
         @(posedge clk);
         #1;
         w++;
      end
      chk("req_ready_before_accept", {31'd0, lsu_if.req_ready}, 32'd1);
      @(posedge clk);
      #1;
      accept_cyc = cyc;
      lsu_if.req_valid = 1'b0;
      exp_idx   = a[17:2];
      exp_err   = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
      exp_store = we;
      exp_rdata = (exp_err || we) ? 32'd0 : model_load(model[a[17:2]], sz, sg, a[1:0]);
      exp_new   = model_store(model[a[17:2]], sz, a[1:0], wd);
      exp_lat   = exp_err ? 1 : ((we && sz != 2'd2) ? 3 : 2);
      exp_wen   = (!exp_err && we) ? 1 : 0;
      wen_base  = wen_count;
      if (!exp_err) chk("ram_addr_access", {16'd0, ram_addr}, {16'd0, exp_idx});
   endtask

   task automatic wait_resp();
      int lat;
      lat = 1;
      while (lsu_if.resp_valid !== 1'b1 && lat < 10) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk("latency", lat, exp_lat);
      chk("resp_err", {31'd0, lsu_if.resp_err}, {31'd0, exp_err});
      chk("resp_rdata", lsu_if.resp_rdata, exp_rdata);
   endtask

   task automatic release_resp(input int delay);
      repeat (delay) begin
         @(posedge clk);
         #1;
         chk("hold_resp_valid", {31'd0, lsu_if.resp_valid}, 32'd1);
         chk("hold_resp_rdata", lsu_if.resp_rdata, exp_rdata);
         chk("hold_req_ready", {31'd0, lsu_if.req_ready}, 32'd0);
      end
      lsu_if.resp_ready = 1'b1;
      @(posedge clk);
      #1;
      lsu_if.resp_ready = 1'b0;
      chk("resp_valid_cleared", {31'd0, lsu_if.resp_valid}, 32'd0);
      chk("req_ready_after_resp", {31'd0, lsu_if.req_ready}, 32'd1);
      chk("wen_pulses", wen_count - wen_base, exp_wen);
      if (exp_store && !exp_err) begin
         model[exp_idx] = exp_new;
         chk("ram_word_after_store", ram[exp_idx], model[exp_idx]);
      end
   endtask

   initial begin
      logic [31:0] tmp;
      logic [15:0] idx;
      logic [1:0]  off;
      logic [1:0]  sz;
      logic        we;
      logic        sg;

      for (int i = 0; i < 65536; i++) begin
         ram[i]   = 32'd0;
         model[i] = 32'd0;
      end
      for (int i = 0; i < 8; i++) begin
         tmp = $urandom();
         ram[i] = tmp;   model[i] = tmp;
         tmp = $urandom();
         ram[16'hFFF8 + i] = tmp;   model[16'hFFF8 + i] = tmp;
      end
      ram[0] = 32'h8899_AABB;  model[0] = 32'h8899_AABB;
      ram[1] = 32'h1122_3344;  model[1] = 32'h1122_3344;

      // reset state; a request held during reset must not be captured
      rst_n = 1'b0;
      lsu_if.req_valid  = 1'b1;
      lsu_if.req_we     = 1'b1;
      lsu_if.req_size   = 2'd2;
      lsu_if.req_signed = 1'b0;
      lsu_if.req_addr   = 32'h0000_1234;
      lsu_if.req_wdata  = 32'hCAFE_F00D;
      lsu_if.resp_ready = 1'b0;
      #12;
      chk("rst_req_ready", {31'd0, lsu_if.req_ready}, 32'd1);
      chk("rst_resp_valid", {31'd0, lsu_if.resp_valid}, 32'd0);
      chk("rst_ram_wen", {31'd0, ram_wen}, 32'd0);
      chk("rst_ram_addr", {16'd0, ram_addr}, 32'd0);
      chk("rst_ram_wdata", ram_wdata, 32'd0);
      chk("rst_resp_rdata", lsu_if.resp_rdata, 32'd0);
      chk("rst_resp_err", {31'd0, lsu_if.resp_err}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      lsu_if.req_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("post_rst_ram_addr", {16'd0, ram_addr}, 32'd0);
      chk("post_rst_req_ready", {31'd0, lsu_if.req_ready}, 32'd1);
      chk("post_rst_ram_word", ram[16'h048D], 32'd0);

      // signed byte load
      send(1'b0, 2'd0, 1'b1, 32'h0000_0001, 32'd0);
      wait_resp();
      chk("lb_const", lsu_if.resp_rdata, 32'hFFFF_FFAA);
      release_resp(0);

      // byte store merged through WRITE
      send(1'b1, 2'd0, 1'b0, 32'h0000_0006, 32'h0000_00EE);
      wait_resp();
      release_resp(0);
      chk("sb_const", ram[1], 32'h11EE_3344);

      // word store at the top of the address space, then half load back
      send(1'b1, 2'd2, 1'b0, 32'h0003_FFFC, 32'hDEAD_BEEF);
      chk("sw_top_wen", {31'd0, ram_wen}, 32'd1);
      chk("sw_top_addr", {16'd0, ram_addr}, 32'h0000_FFFF);
      wait_resp();
      release_resp(0);
      chk("sw_top_const", ram[16'hFFFF], 32'hDEAD_BEEF);
      send(1'b0, 2'd1, 1'b0, 32'h0003_FFFE, 32'd0);
      wait_resp();
      chk("lhu_const", lsu_if.resp_rdata, 32'h0000_DEAD);
      release_resp(0);

      // misaligned accesses
      send(1'b0, 2'd2, 1'b0, 32'h0000_0002, 32'd0);
      wait_resp();
      release_resp(1);
      send(1'b1, 2'd1, 1'b0, 32'h0000_0005, 32'h0000_7777);
      wait_resp();
      release_resp(2);

      // response stall with a second request held
      send(1'b0, 2'd2, 1'b0, 32'h0000_0008, 32'd0);
      wait_resp();
      fork
         send(1'b0, 2'd0, 1'b0, 32'h0000_000D, 32'd0);
         begin
            repeat (5) begin
               @(posedge clk);
               #1;
               chk("stall_resp_valid", {31'd0, lsu_if.resp_valid}, 32'd1);
               chk("stall_resp_rdata", lsu_if.resp_rdata, exp_rdata);
               chk("stall_req_ready", {31'd0, lsu_if.req_ready}, 32'd0);
            end
            lsu_if.resp_ready = 1'b1;
            @(posedge clk);
            #1;
            lsu_if.resp_ready = 1'b0;
            idle_cyc = cyc;
            chk("stall_resp_cleared", {31'd0, lsu_if.resp_valid}, 32'd0);
            chk("stall_idle_ready", {31'd0, lsu_if.req_ready}, 32'd1);
         end
      join
      chk("b2b_accept_cycle", accept_cyc, idle_cyc + 1);
      chk("b2b_busy", {31'd0, lsu_if.req_ready}, 32'd0);
      wait_resp();
      release_resp(1);

      // reset in the middle of WRITE
      send(1'b1, 2'd0, 1'b0, 32'h0000_0009, 32'h0000_0055);
      @(posedge clk);
      #1;
      chk("write_wen", {31'd0, ram_wen}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("abort_wen_drop", {31'd0, ram_wen}, 32'd0);
      chk("abort_resp_valid", {31'd0, lsu_if.resp_valid}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      chk("abort_ram_unchanged", ram[2], model[2]);
      chk("abort_no_wen", wen_count - wen_base, 32'd0);
      rst_n = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
         chk("abort_no_resp", {31'd0, lsu_if.resp_valid}, 32'd0);
      end
      chk("abort_req_ready", {31'd0, lsu_if.req_ready}, 32'd1);
      chk("abort_ram_addr", {16'd0, ram_addr}, 32'd0);

      // random traffic
      for (int t = 0; t < 60; t++) begin
         idx = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 7))
                                           : 16'(16'hFFF8 + $urandom_range(0, 7));
         off = 2'($urandom_range(0, 3));
         sz  = 2'($urandom_range(0, 3));
         we  = 1'($urandom_range(0, 1));
         sg  = 1'($urandom_range(0, 1));
         tmp = $urandom();
         send(we, sz, sg, {tmp[31:18], idx, off}, $urandom());
         wait_resp();
         release_resp($urandom_range(0, 3));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/dram_lsu.md
DRAM_LSU -- requirements
Module: dram_lsu

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous active-low reset.
REQ-003 req_valid  input  1  pipeline memory request present.
REQ-004 req_ready  output  1  high exactly when state is IDLE; request accepted on rising edge with req_valid && req_ready.
REQ-005 req_we  input  1  1 = store, 0 = load.
REQ-006 req_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-007 req_signed  input  1  loads: 1 sign-extends, 0 zero-extends.
REQ-008 req_addr  input  32  byte address; bits [31:18] ignored.
REQ-009 req_wdata  input  32  store data, right-justified for byte/half.
REQ-010 resp_valid  output  1  response present; held until resp_ready.
REQ-011 resp_ready  input  1  pipeline accepts response.
REQ-012 resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-013 resp_err  output  1  misaligned access or reserved size.
REQ-014 ram_addr  output  16  word index to data RAM, equal to captured addr[17:2].
REQ-015 ram_wdata  output  32  full word to write.
REQ-016 ram_wen  output  1  word write enable; RAM writes on falling edge, reads combinationally.
REQ-017 ram_rdata  input  32  combinational read data for ram_addr.

Function
REQ-018 FSM states: IDLE, ACCESS, WRITE, RESP.
REQ-019 On acceptance: capture we/size/signed/addr/wdata; go ACCESS, or RESP with resp_err=1 if half with addr[0]=1, word with addr[1:0]!=0, or size 11; an erroring request never asserts ram_wen.
REQ-020 Lanes little-endian: byte n of word = bits [8n+7:8n]; byte lane addr[1:0], half lane addr[1].
REQ-021 ACCESS, load: extract lane from ram_rdata, extend per signed, register into resp_rdata; next RESP.
REQ-022 ACCESS, word store: ram_wen=1, ram_wdata=captured wdata for that cycle only; next RESP.
REQ-023 ACCESS, byte/half store: ram_wen=0; merge wdata lane into ram_rdata, register merged word; next WRITE.
REQ-024 WRITE: ram_wen=1, ram_wdata=merged word, one cycle; next RESP.
REQ-025 RESP: resp_valid=1; on resp_ready go IDLE, clearing resp_valid next cycle; back-to-back request accepted earliest one cycle later.
REQ-026 Latency accept-to-resp_valid: load / word store 2 cycles; byte/half store 3; error 1.
REQ-027 ram_wen=1 only in ACCESS (word store) or WRITE; ram_addr stable from ACCESS through end of WRITE.
REQ-028 Outputs other than resp_* change only in ACCESS/WRITE; resp_rdata/resp_err stable while resp_valid.

Reset
REQ-029 rst_n low: state IDLE, ram_wen=0 immediately, ram_addr=0, ram_wdata=0, resp_valid=0, resp_rdata=0, resp_err=0, all captured fields 0.
REQ-030 Reset during ACCESS/WRITE aborts the transaction; a write is suppressed if rst_n falls before that cycle's falling edge; no response is issued.
REQ-031 req_ready is 1 in reset state, but no request is captured while rst_n is low.

Structure
REQ-032 Shared package holds size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), FSM state encoding, RAM address width 16.
REQ-033 One combinational sub-module lsu_lane_align: load extraction/extension and store merge.

Verification
REQ-034 RAM[0]=0x8899AABB; lb signed addr 0x1 -> resp_rdata 0xFFFFFFAA, resp_valid 2 cycles after accept.
REQ-035 RAM[1]=0x11223344; sb 0x000000EE at addr 0x6 -> one ram_wen pulse in WRITE, RAM[1]=0x11EE3344, resp_valid 3 cycles after accept.
REQ-036 sw 0xDEADBEEF at addr 0x3FFFC -> ram_addr 0xFFFF, RAM[0xFFFF]=0xDEADBEEF; lhu addr 0x3FFFE -> 0x0000DEAD.
REQ-037 lw addr 0x2 and sh addr 0x5 -> resp_err=1, resp_rdata=0, ram_wen never high, resp_valid 1 cycle after accept.
REQ-038 resp_ready held low 5 cycles -> resp_valid/resp_rdata stable, req_ready=0; second req_valid held is accepted the cycle after IDLE.
REQ-039 rst_n pulled low mid-WRITE before falling edge -> ram_wen drops at once, RAM unchanged, no resp_valid, req_ready=1 after release.
